// File: rtl/rca8_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rca8_word_sequencer (with leaf rca_8)
// Description : Multi-byte add engine. Accepts NBYTES-wide operands over a
//               valid/ready handshake, feeds one rca_8 one byte per cycle
//               (LSB first, carry chained between bytes) and presents the
//               full-width sum, carry-out and signed overflow downstream.
//               Optional feature macro: SUBTRACT_EN (adds in_sub, A-B mode).
// Revision    : 1.0 - initial release
// ============================================================================

// 8-bit ripple-carry adder used as the per-byte datapath element.
module rca_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_s,
    output logic       o_cout
);

    logic [8:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign o_s[gi]     = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[8];

endmodule

module rca8_word_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
`ifdef SUBTRACT_EN
    input  logic                  in_sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam int c_w  = 8 * NBYTES;
    localparam int c_iw = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [c_iw-1:0] c_last_idx = c_iw'(NBYTES - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]      r_state;
    logic [c_w-1:0]  r_a;
    logic [c_w-1:0]  r_b;
    logic            r_sub;
    logic            r_carry;
    logic [c_iw-1:0] r_idx;
    logic [c_w-1:0]  r_result;
    logic            r_cout;
    logic            r_ovf;

    logic            w_sub_req;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_b_eff;
    logic [7:0]      w_s;
    logic            w_cout;

`ifdef SUBTRACT_EN
    assign w_sub_req = in_sub;
`else
    assign w_sub_req = 1'b0;
`endif

    // Select the operand bytes addressed by the current byte index.
    always_comb begin
        w_a_byte = 8'h00;
        w_b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == c_iw'(i)) begin
                w_a_byte = r_a[i*8 +: 8];
                w_b_byte = r_b[i*8 +: 8];
            end
        end
    end

    // Subtraction is A + ~B + 1; the forced carry-in is applied at accept time.
    assign w_b_eff = w_b_byte ^ {8{r_sub}};

    rca_8 u_rca_8 (
        .i_a    (w_a_byte),
        .i_b    (w_b_eff),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Control FSM and datapath registers: accept, byte-serial ripple, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_sub    <= w_sub_req;
                        r_carry  <= w_sub_req | in_cin;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= c_run;
                    end
                end
                c_run: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == c_iw'(i)) begin
                            r_result[i*8 +: 8] <= w_s;
                        end
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + c_iw'(1);
                    if (r_idx == c_last_idx) begin
                        // Overflow uses the effective (possibly inverted) B sign bit.
                        r_cout  <= w_cout;
                        r_ovf   <= w_a_byte[7] ^ w_b_eff[7] ^ w_s[7] ^ w_cout;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign out_sum   = r_result;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire
